// File: rtl/serial_motor_rx.sv
`timescale 1ns/1ps
// serial_motor_rx: decodes framed serial motor commands (sync 1,0,1, data,
// optional even parity, stop 0) into per-channel enable/direction outputs.
// A loss-of-link watchdog forces every enable low when valid frames stop.
module serial_motor_rx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int NUM_CH       = 2,
  parameter int PARITY_EN    = 1,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic              Clk_In,
  input  logic              Reset_In,
  input  logic              Serial_In,
  output logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] dir,
  output logic              frame_valid,
  output logic              frame_error,
  output logic              link_timeout,
  output logic              busy
);

  localparam int DATA_W   = 2 * NUM_CH;
  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_MAX  = (DATA_W > 3) ? DATA_W : 3;
  localparam int IDX_W    = $clog2(IDX_MAX);
  localparam int WD_W     = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] CNT_SAMPLE    = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_AFTER_RISE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_SYNC_MID  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_SYNC_LAST = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT      = WD_W'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, STOP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_sMeta;
  logic                r_sSync;
  logic                r_sPrev;
  logic [CNT_W-1:0]    r_bitCnt;
  logic [IDX_W-1:0]    r_bitIdx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parityBit;
  logic [NUM_CH-1:0]   r_en;
  logic [NUM_CH-1:0]   r_dir;
  logic                r_frameValid;
  logic                r_frameError;
  logic                r_linkTimeout;
  logic [WD_W-1:0]     r_wdCnt;

  logic                w_rise;
  logic                w_sample;
  logic                w_bitEnd;
  logic                w_syncExpect;
  logic                w_parityOk;
  logic                w_startFrame;
  logic                w_shiftEn;
  logic                w_parityLd;
  logic                w_goodFrame;
  logic                w_badFrame;
  logic [WD_W-1:0]     w_wdNext;
  logic                w_wdExpired;
  logic [NUM_CH-1:0]   w_frameEn;
  logic [NUM_CH-1:0]   w_frameDir;

  assign w_rise       = r_sSync & ~r_sPrev;
  assign w_sample     = (r_bitCnt == CNT_SAMPLE);
  assign w_bitEnd     = (r_bitCnt == CNT_LAST);
  assign w_syncExpect = (r_bitIdx != IDX_SYNC_MID);
  assign w_parityOk   = (PARITY_EN == 0) || ((^r_shift) == r_parityBit);

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_sMeta <= 1'b0;
      r_sSync <= 1'b0;
      r_sPrev <= 1'b0;
    end else begin
      r_sMeta <= Serial_In;
      r_sSync <= r_sMeta;
      r_sPrev <= r_sSync;
    end
  end

  // FSM state register
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state decode and per-sample actions; the rise cycle counts as bit 0, count 0
  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_shiftEn    = 1'b0;
    w_parityLd   = 1'b0;
    w_goodFrame  = 1'b0;
    w_badFrame   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_nextState  = SYNC;
          w_startFrame = 1'b1;
        end
      end
      SYNC: begin
        if (w_sample && (r_sSync != w_syncExpect)) w_nextState = IDLE;
        else if (w_bitEnd && (r_bitIdx == IDX_SYNC_LAST)) w_nextState = DATA;
      end
      DATA: begin
        w_shiftEn = w_sample;
        if (w_bitEnd && (r_bitIdx == IDX_DATA_LAST))
          w_nextState = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        w_parityLd = w_sample;
        if (w_bitEnd) w_nextState = STOP;
      end
      STOP: begin
        if (w_sample) begin
          w_nextState = IDLE;
          if (!r_sSync && w_parityOk) w_goodFrame = 1'b1;
          else                        w_badFrame  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Bit-period counter and bit index within the current field
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_bitCnt <= '0;
      r_bitIdx <= '0;
    end else if (w_startFrame) begin
      r_bitCnt <= CNT_AFTER_RISE;
      r_bitIdx <= '0;
    end else if (w_nextState == IDLE) begin
      r_bitCnt <= '0;
      r_bitIdx <= '0;
    end else if (w_bitEnd) begin
      r_bitCnt <= '0;
      r_bitIdx <= (w_nextState != r_state) ? '0 : r_bitIdx + 1'b1;
    end else begin
      r_bitCnt <= r_bitCnt + 1'b1;
    end
  end

  // Data shift register (first bit ends up at the MSB) and stored parity sample
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_shift     <= '0;
      r_parityBit <= 1'b0;
    end else begin
      if (w_shiftEn)  r_shift     <= {r_shift[DATA_W-2:0], r_sSync};
      if (w_parityLd) r_parityBit <= r_sSync;
    end
  end

  // Unpack the data field: channel c owns bits {en,dir} at [2c+1:2c]
  always_comb begin
    w_frameEn  = '0;
    w_frameDir = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_frameEn[c]  = r_shift[2*c+1];
      w_frameDir[c] = r_shift[2*c];
    end
  end

  // Saturating watchdog; a good frame on the expiry cycle takes priority
  always_comb begin
    w_wdNext = r_wdCnt;
    if (w_goodFrame)             w_wdNext = '0;
    else if (r_wdCnt != WD_LIMIT) w_wdNext = r_wdCnt + 1'b1;
    w_wdExpired = (w_wdNext == WD_LIMIT);
  end

  // Registered outputs: enables/directions move only on a good frame or expiry
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_en          <= '0;
      r_dir         <= '0;
      r_frameValid  <= 1'b0;
      r_frameError  <= 1'b0;
      r_linkTimeout <= 1'b0;
      r_wdCnt       <= '0;
    end else begin
      r_frameValid  <= w_goodFrame;
      r_frameError  <= w_badFrame;
      r_wdCnt       <= w_wdNext;
      r_linkTimeout <= w_wdExpired;
      if (w_goodFrame) begin
        r_en  <= w_frameEn;
        r_dir <= w_frameDir;
      end else if (w_wdExpired) begin
        r_en  <= '0;
      end
    end
  end

  assign en           = r_en;
  assign dir          = r_dir;
  assign frame_valid  = r_frameValid;
  assign frame_error  = r_frameError;
  assign link_timeout = r_linkTimeout;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_serial_motor_rx.sv
`timescale 1ns/1ps
// tb_serial_motor_rx: drives directed and random serial frames; a reference
// model predicts each frame's outcome into a queue that a monitor drains
// whenever the receiver pulses frame_valid or frame_error.
module tb_serial_motor_rx;

  localparam int CPB = 2;
  localparam int NCH = 2;
  localparam int DW  = 2 * NCH;

  typedef struct packed {
    logic           isValid;
    logic [NCH-1:0] en;
    logic [NCH-1:0] dir;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           sin;
  logic [NCH-1:0] en;
  logic [NCH-1:0] dir;
  logic           frameValid;
  logic           frameError;
  logic           linkTimeout;
  logic           busy;

  exp_t           expQ[$];
  logic [NCH-1:0] curEn;
  logic [NCH-1:0] curDir;
  int             checks = 0;
  int             passes = 0;
  int             busyRises = 0;
  logic           busyPrev = 1'b0;

  serial_motor_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_CH(NCH),
    .PARITY_EN(1),
    .TIMEOUT_CLKS(1000)
  ) dut (
    .Clk_In(clk),
    .Reset_In(rst),
    .Serial_In(sin),
    .en(en),
    .dir(dir),
    .frame_valid(frameValid),
    .frame_error(frameError),
    .link_timeout(linkTimeout),
    .busy(busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model: decide a frame's outcome from the wire-level bit list
  function automatic bit modelFrame(input logic [2:0] syncBits, input logic [DW-1:0] data,
                                    input logic parBit, input logic stopBit, output exp_t e);
    logic seq[DW];
    int   ones;
    e = '0;
    if (syncBits != 3'b101) return 1'b0;
    ones = 0;
    for (int k = 0; k < DW; k++) begin
      seq[k] = data[DW-1-k];
      if (seq[k]) ones++;
    end
    if (stopBit != 1'b0 || ((ones + int'(parBit)) % 2) != 0) begin
      e.isValid = 1'b0;
      return 1'b1;
    end
    e.isValid = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      e.en[ch]  = seq[2*(NCH-1-ch)];
      e.dir[ch] = seq[2*(NCH-1-ch)+1];
    end
    return 1'b1;
  endfunction

  task automatic driveBit(input logic b);
    sin = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Drives sync bits, and when fullFrame is set also data, parity and stop
  task automatic applyStimulus(input logic [2:0] syncBits, input logic [DW-1:0] data,
                               input logic parBit, input logic stopBit, input bit fullFrame);
    for (int i = 2; i >= 0; i--) driveBit(syncBits[i]);
    if (fullFrame) begin
      for (int i = DW-1; i >= 0; i--) driveBit(data[i]);
      driveBit(parBit);
      driveBit(stopBit);
    end
    sin = 1'b0;
  endtask

  task automatic sendFrame(input logic [2:0] syncBits, input logic [DW-1:0] data,
                           input logic parBit, input logic stopBit, input int gap);
    exp_t e;
    if (modelFrame(syncBits, data, parBit, stopBit, e)) begin
      expQ.push_back(e);
      applyStimulus(syncBits, data, parBit, stopBit, 1'b1);
    end else begin
      applyStimulus(syncBits, data, parBit, stopBit, 1'b0);
    end
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && expQ.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue drained", expQ.size(), 0);
  endtask

  // Monitor: every pulse must match the oldest predicted outcome
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frameValid || frameError)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse", {frameValid, frameError}, 2'b00);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse kind", {frameValid, frameError}, e.isValid ? 2'b10 : 2'b01);
        if (e.isValid) begin
          curEn  = e.en;
          curDir = e.dir;
          checkOutput("link_timeout on valid", linkTimeout, 1'b0);
        end
        checkOutput("en after pulse", en, curEn);
        checkOutput("dir after pulse", dir, curDir);
      end
    end
  end

  // Counts SYNC attempts as rising edges of busy
  always @(negedge clk) begin
    if (busy && !busyPrev) busyRises++;
    busyPrev = busy;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DW-1:0] data;
    logic          par;
    logic          stop;
    logic [2:0]    syncBits;
    int            kind;
    int            rises;

    rst = 1'b1;
    sin = 1'b0;
    curEn = '0;
    curDir = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset en", en, 0);
    checkOutput("reset dir", dir, 0);
    checkOutput("reset frame_valid", frameValid, 0);
    checkOutput("reset frame_error", frameError, 0);
    checkOutput("reset link_timeout", linkTimeout, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] good frame");
    sendFrame(3'b101, 4'b1011, 1'b1, 1'b0, 3);
    drain();
    checkOutput("s1 en", en, 2'b11);
    checkOutput("s1 dir", dir, 2'b01);

    $display("[TB] parity error frame");
    sendFrame(3'b101, 4'b1011, 1'b0, 1'b0, 3);
    drain();
    checkOutput("s2 en held", en, 2'b11);
    checkOutput("s2 dir held", dir, 2'b01);

    $display("[TB] bad sync then good frame");
    sendFrame(3'b111, 4'b0000, 1'b0, 1'b0, 10);
    checkOutput("s3 busy low", busy, 0);
    checkOutput("s3 en unchanged", en, 2'b11);
    sendFrame(3'b101, 4'b0010, 1'b1, 1'b0, 3);
    drain();
    checkOutput("s3 en", en, 2'b01);
    checkOutput("s3 dir", dir, 2'b00);

    $display("[TB] watchdog");
    sendFrame(3'b101, 4'b1101, 1'b1, 1'b0, 3);
    drain();
    repeat (880) @(posedge clk);
    #1;
    checkOutput("s4 before expiry timeout", linkTimeout, 0);
    checkOutput("s4 before expiry en", en, 2'b10);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("s4 expired timeout", linkTimeout, 1);
    checkOutput("s4 expired en", en, 2'b00);
    checkOutput("s4 expired dir", dir, 2'b11);
    curEn = '0;
    sendFrame(3'b101, 4'b1011, 1'b1, 1'b0, 3);
    drain();
    checkOutput("s4 recovered timeout", linkTimeout, 0);
    checkOutput("s4 recovered en", en, 2'b11);

    $display("[TB] reset mid-frame");
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    sin = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("s5 reset en", en, 0);
    checkOutput("s5 reset dir", dir, 0);
    checkOutput("s5 reset busy", busy, 0);
    curEn = '0;
    curDir = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("s5 busy after tail", busy, 0);
    checkOutput("s5 en after tail", en, 0);
    sendFrame(3'b101, 4'b0111, 1'b1, 1'b0, 3);
    drain();
    checkOutput("s5 en", en, 2'b01);
    checkOutput("s5 dir", dir, 2'b11);

    $display("[TB] line stuck high");
    sendFrame(3'b101, 4'b1110, 1'b1, 1'b0, 3);
    drain();
    rises = busyRises;
    sin = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("s6 sync attempts", busyRises - rises, 1);
    checkOutput("s6 busy low", busy, 0);
    checkOutput("s6 en held", en, 2'b11);
    sin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sendFrame(3'b101, 4'b1001, 1'b0, 1'b0, 3);
    drain();
    checkOutput("s6 en", en, 2'b10);

    $display("[TB] random frames");
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 5);
      data = DW'($urandom);
      par = ^data;
      stop = 1'b0;
      syncBits = 3'b101;
      if (kind == 3) par = ~par;
      if (kind == 4) stop = 1'b1;
      if (kind == 5) syncBits = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b100;
      sendFrame(syncBits, data, par, stop, $urandom_range(2, 6));
    end
    drain();
    checkOutput("final link_timeout", linkTimeout, 0);
    checkOutput("final busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
